enemy_hit_judge: RTL

- Pixel-stream collision judge that sits directly upstream of the enemy spawner/mover.
- Watches the per-pixel enemy valid/index outputs alongside the bullet and player-plane pixel valids during the active frame, and accumulates hits per enemy slot.
- At frame blanking it walks the slots, decrements hit points, and drives the per-slot disappear vector consumed by the enemy block.
- Also reports a player-hit pulse.

---
 rtl/enemy_hit_judge.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/enemy_hit_judge.sv
// Pixel-stream collision judge: accumulates per-slot bullet/plane hits each frame,
// settles HP at blanking and drives the per-slot disappear vector.
// Optional hit-flash output is enabled with `define HIT_FLASH_EN.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   SCAN   | active frame, latching sticky hit/crash flags per slot
//   SETTLE | blanking, one slot per cycle: HP update, kill decision
//   HOLD   | disappear_o = kill vector for DISAPPEAR_HOLD cycles
//   WAIT   | kill cleared, waiting for the next active frame
module enemy_hit_judge #(
    parameter int MAX_ENEMY_NUM         = 10,
    parameter int MAX_ENEMY_NUM_BIT_LEN = 4,
    parameter int ENEMY_HP              = 3,
    parameter int HP_BIT_LEN            = 2,
    parameter int DISAPPEAR_HOLD        = 8
) (
    input  logic                             clk_vga,
    input  logic                             rst_n,
    input  logic                             v_sync_i,
    input  logic                             enemy_vali_i,
    input  logic [MAX_ENEMY_NUM_BIT_LEN-1:0] curr_enemy_idx_i,
    input  logic                             bullet_vali_i,
    input  logic                             plane_vali_i,
    input  logic                             trigger_i,
    input  logic [MAX_ENEMY_NUM_BIT_LEN-1:0] trigger_idx_i,
    output logic [MAX_ENEMY_NUM-1:0]         disappear_o,
    output logic                             player_hit_o,
    output logic                             flash_o
);

    localparam int HOLD_W = $clog2(DISAPPEAR_HOLD + 1);
    localparam logic [HP_BIT_LEN-1:0] HP_INIT = HP_BIT_LEN'(ENEMY_HP);
    localparam logic [MAX_ENEMY_NUM_BIT_LEN-1:0] LAST_SLOT =
        MAX_ENEMY_NUM_BIT_LEN'(MAX_ENEMY_NUM - 1);

    typedef enum logic [1:0] {
        S_SCAN   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic                             r_vsync_d;
    logic [MAX_ENEMY_NUM_BIT_LEN-1:0] r_ptr;
    logic [HOLD_W-1:0]                r_hold_cnt;
    logic [MAX_ENEMY_NUM-1:0]         r_hit;
    logic [MAX_ENEMY_NUM-1:0]         r_crash;
    logic [MAX_ENEMY_NUM-1:0]         r_kill;
    logic [HP_BIT_LEN-1:0]            r_hp [MAX_ENEMY_NUM];
    logic                             r_crash_seen;
    logic                             r_player_hit;

    logic [MAX_ENEMY_NUM-1:0]         w_pix_sel;
    logic [MAX_ENEMY_NUM-1:0]         w_trig_sel;
    logic [MAX_ENEMY_NUM-1:0]         w_ptr_sel;
    logic                             w_fall;
    logic                             w_last;
    logic                             w_hold_done;
    logic                             w_cur_crash;

    // One-hot slot decodes; out-of-range indices decode to all zeros.
    always_comb begin
        w_pix_sel  = '0;
        w_trig_sel = '0;
        w_ptr_sel  = '0;
        for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
            w_pix_sel[i]  = (curr_enemy_idx_i == MAX_ENEMY_NUM_BIT_LEN'(i));
            w_trig_sel[i] = trigger_i && (trigger_idx_i == MAX_ENEMY_NUM_BIT_LEN'(i));
            w_ptr_sel[i]  = (r_ptr == MAX_ENEMY_NUM_BIT_LEN'(i));
        end
    end

    assign w_fall      = r_vsync_d & ~v_sync_i;
    assign w_last      = (r_ptr == LAST_SLOT);
    assign w_hold_done = (r_hold_cnt == '0);
    assign w_cur_crash = |(r_crash & w_ptr_sel);

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_state <= S_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SCAN:   if (w_fall)      w_state_nxt = S_SETTLE;
            S_SETTLE: if (w_last)      w_state_nxt = S_HOLD;
            S_HOLD:   if (w_hold_done) w_state_nxt = S_WAIT;
            S_WAIT:   if (v_sync_i)    w_state_nxt = S_SCAN;
            default:                   w_state_nxt = S_SCAN;
        endcase
    end

    always_comb begin
        disappear_o  = '0;
        player_hit_o = r_player_hit;
        if (r_state == S_HOLD) begin
            disappear_o = r_kill;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_vsync_d    <= 1'b0;
            r_ptr        <= '0;
            r_hold_cnt   <= '0;
            r_hit        <= '0;
            r_crash      <= '0;
            r_kill       <= '0;
            r_crash_seen <= 1'b0;
            r_player_hit <= 1'b0;
            for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                r_hp[i] <= HP_INIT;
            end
        end else begin
            r_vsync_d    <= v_sync_i;
            r_player_hit <= 1'b0;
            case (r_state)
                S_SCAN: begin
                    for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                        if (enemy_vali_i && w_pix_sel[i]) begin
                            if (bullet_vali_i) r_hit[i]   <= 1'b1;
                            if (plane_vali_i)  r_crash[i] <= 1'b1;
                        end
                    end
                    if (w_fall) begin
                        r_ptr        <= '0;
                        r_crash_seen <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                        if (w_ptr_sel[i]) begin
                            if (r_crash[i]) begin
                                r_kill[i] <= 1'b1;
                                r_hp[i]   <= '0;
                            end else if (r_hit[i] && r_hp[i] > HP_BIT_LEN'(1)) begin
                                r_hp[i] <= r_hp[i] - HP_BIT_LEN'(1);
                            end else if (r_hit[i] && r_hp[i] == HP_BIT_LEN'(1)) begin
                                r_hp[i]   <= '0;
                                r_kill[i] <= 1'b1;
                            end
                            r_hit[i]   <= 1'b0;
                            r_crash[i] <= 1'b0;
                        end
                    end
                    r_crash_seen <= r_crash_seen | w_cur_crash;
                    if (w_last) begin
                        r_player_hit <= r_crash_seen | w_cur_crash;
                        r_hold_cnt   <= HOLD_W'(DISAPPEAR_HOLD - 1);
                    end else begin
                        r_ptr <= r_ptr + MAX_ENEMY_NUM_BIT_LEN'(1);
                    end
                end
                S_HOLD: begin
                    if (w_hold_done) begin
                        r_kill <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                default: ;
            endcase
            // Spawn is applied last so it overrides same-cycle settle/detect updates.
            for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                if (w_trig_sel[i]) begin
                    r_hp[i]    <= HP_INIT;
                    r_hit[i]   <= 1'b0;
                    r_crash[i] <= 1'b0;
                    r_kill[i]  <= 1'b0;
                end
            end
        end
    end

`ifdef HIT_FLASH_EN
    logic [MAX_ENEMY_NUM-1:0] r_flash_mask;
    logic                     r_flash;

    // Mask marks slots hit-but-surviving in the last settled frame.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_flash_mask <= '0;
            r_flash      <= 1'b0;
        end else begin
            r_flash <= enemy_vali_i & (|(r_flash_mask & w_pix_sel));
            for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                if (r_state == S_SETTLE && w_ptr_sel[i]) begin
                    r_flash_mask[i] <= r_hit[i] &
                        ~(r_crash[i] | (r_hit[i] && r_hp[i] == HP_BIT_LEN'(1)));
                end
                if (w_trig_sel[i]) begin
                    r_flash_mask[i] <= 1'b0;
                end
            end
        end
    end

    assign flash_o = r_flash;
`else
    assign flash_o = 1'b0;
`endif

endmodule
